uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter, successor to the fixed-format TX. It has an internal baud divisor, so no external bit_tick is needed. Data length (5..MAX_DATA_BITS), parity and stop bits are set per frame from config inputs. A one-entry holding register allows gapless back-to-back frames. Sits between the stream source and the txd pad in the UART top.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_tx_cfg_baud_gen.sv | 33 +++
 rtl/uart_tx_cfg.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// +-------------------------------------------------------------------------+
// | uart_pkg : shared types, constants and parity helper for the UART TX.   |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_tx_state_e;

  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_PAR_MAX_W     = 64;

  // Parity over the low 'len' bits only; bits above the frame length are masked out.
  function automatic logic parity_calc(
    input logic [UART_PAR_MAX_W-1:0] data,
    input int                        len,
    input parity_e                   mode
  );
    logic ones;
    ones = 1'b0;
    for (int i = 0; i < UART_PAR_MAX_W; i++) begin
      if (i < len) ones = ones ^ data[i];
    end
    case (mode)
      PARITY_EVEN: parity_calc = ones;
      PARITY_ODD:  parity_calc = ~ones;
      default:     parity_calc = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_cfg_baud_gen.sv
// +-------------------------------------------------------------------------+
// | uart_baud_gen : bit-period counter, one-cycle bit_tick per period end.  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] divisor,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == divisor)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign bit_tick = (cnt == divisor);

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// +-------------------------------------------------------------------------+
// | uart_tx_cfg : runtime-configurable UART transmitter with holding reg.   |
// | Optional macro UART_TX_CTS_EN adds the cts_n flow-control input. r1.0   |
// +-------------------------------------------------------------------------+
`default_nettype none

module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 8,
  parameter int DIV_W         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIV_W-1:0]                   cfg_divisor,
  input  logic [$clog2(MAX_DATA_BITS+1)-1:0] cfg_data_bits,
  input  parity_e                            cfg_parity,
  input  logic                               cfg_stop2,
  input  logic                               tx_valid,
  input  logic [MAX_DATA_BITS-1:0]           tx_data,
`ifdef UART_TX_CTS_EN
  input  logic                               cts_n,
`endif
  output logic                               tx_ready,
  output logic                               txd,
  output logic                               busy
);

  localparam int LEN_W = $clog2(MAX_DATA_BITS+1);

  uart_tx_state_e           state, state_next;
  logic                     hold_valid;
  logic [MAX_DATA_BITS-1:0] hold_data;
  logic [MAX_DATA_BITS-1:0] shift_reg;
  logic [LEN_W-1:0]         bit_cnt;
  logic [LEN_W-1:0]         last_idx;
  logic [LEN_W-1:0]         len_clamped;
  parity_e                  par_mode;
  logic                     par_bit;
  logic                     stop2_lat;
  logic                     stop_cnt;
  logic [DIV_W-1:0]         div_lat;
  logic                     bit_tick;
  logic                     frame_start;
  logic                     start_ok;
  logic                     txd_bit;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end

  assign start_ok = hold_valid && !cts_sync[1];
`else
  assign start_ok = hold_valid;
`endif

  assign tx_ready = !hold_valid;
  assign busy     = (state != S_IDLE);

  always_comb begin
    len_clamped = cfg_data_bits;
    if (cfg_data_bits < LEN_W'(UART_MIN_DATA_BITS)) begin
      len_clamped = LEN_W'(UART_MIN_DATA_BITS);
    end else if (cfg_data_bits > LEN_W'(MAX_DATA_BITS)) begin
      len_clamped = LEN_W'(MAX_DATA_BITS);
    end
  end

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (frame_start),
    .divisor  (div_lat),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_next  = S_START;
          frame_start = 1'b1;
        end
      end
      S_START: begin
        if (bit_tick) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_tick && (bit_cnt == last_idx)) begin
          state_next = (par_mode != PARITY_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_tick) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_tick && (stop_cnt == stop2_lat)) begin
          // Gapless continuation when the next beat is already held.
          if (start_ok) begin
            state_next  = S_START;
            frame_start = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    txd_bit = 1'b1;
    case (state)
      S_START:  txd_bit = 1'b0;
      S_DATA:   txd_bit = shift_reg[0];
      S_PARITY: txd_bit = par_bit;
      default:  txd_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      last_idx   <= '0;
      par_mode   <= PARITY_NONE;
      par_bit    <= 1'b0;
      stop2_lat  <= 1'b0;
      stop_cnt   <= 1'b0;
      div_lat    <= '0;
      txd        <= 1'b1;
    end else begin
      txd <= txd_bit;
      if (frame_start) begin
        // Config is sampled here so mid-frame changes only affect the next frame.
        hold_valid <= 1'b0;
        shift_reg  <= hold_data;
        bit_cnt    <= '0;
        last_idx   <= len_clamped - LEN_W'(1);
        par_mode   <= cfg_parity;
        par_bit    <= parity_calc(UART_PAR_MAX_W'(hold_data), int'(len_clamped), cfg_parity);
        stop2_lat  <= cfg_stop2;
        stop_cnt   <= 1'b0;
        div_lat    <= cfg_divisor;
      end else begin
        if (tx_valid && tx_ready) begin
          hold_valid <= 1'b1;
          hold_data  <= tx_data;
        end
        if (bit_tick && (state == S_DATA)) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + LEN_W'(1);
        end
        if (bit_tick && (state == S_STOP)) begin
          stop_cnt <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// +-------------------------------------------------------------------------+
// | tb_uart_tx_cfg : self-checking bench, frame-level reference model.      |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_divisor;
  logic [3:0]  cfg_data_bits;
  parity_e     cfg_parity;
  logic        cfg_stop2;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        txd;
  logic        busy;
`ifdef UART_TX_CTS_EN
  logic        cts_n;
`endif

  int checks = 0;
  int errors = 0;
  logic exp_bits[$];

  uart_tx_cfg #(
    .MAX_DATA_BITS (8),
    .DIV_W         (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_divisor   (cfg_divisor),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
`ifdef UART_TX_CTS_EN
    .cts_n         (cts_n),
`endif
    .tx_ready      (tx_ready),
    .txd           (txd),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start, N data bits LSB first, optional parity, stop bit(s).
  task automatic build_frame(input logic [7:0] data, input int nb_cfg, input int par, input bit stop2);
    int n;
    int ones;
    logic [7:0] mask;
    logic p;
    n = (nb_cfg < 5) ? 5 : ((nb_cfg > 8) ? 8 : nb_cfg);
    mask = (8'd1 << n) - 8'd1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) exp_bits.push_back(data[i]);
    if (par != 0) begin
      ones = $countones(data & mask);
      p = ((ones % 2) != 0);
      if (par == 2) p = !p;
      exp_bits.push_back(p);
    end
    exp_bits.push_back(1'b1);
    if (stop2) exp_bits.push_back(1'b1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy !== 1'b0 || tx_ready !== 1'b1) && t < 2000) begin
      step();
      t++;
    end
    check("idle_before_frame", {busy, tx_ready}, 2'b01);
  endtask

  // Called at the sample right after the frame-start edge.
  task automatic check_frame(input string tag, input int div);
    int busy_cnt;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int k = 0; k <= div; k++) begin
        step();
        check($sformatf("%s_bit%0d_clk%0d", tag, b, k), txd, exp_bits[b]);
        if (busy === 1'b1) busy_cnt++;
      end
    end
    check({tag, "_busy_clocks"}, busy_cnt, exp_bits.size() * (div + 1));
    step();
    check({tag, "_txd_idle_after"}, txd, 1'b1);
    check({tag, "_busy_low_after"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input int nb, input int par,
                           input bit stop2, input int div);
    wait_idle();
    cfg_divisor   = 16'(div);
    cfg_data_bits = 4'(nb);
    cfg_parity    = parity_e'(par);
    cfg_stop2     = stop2;
    tx_data       = data;
    tx_valid      = 1'b1;
    step();
    tx_valid = 1'b0;
    check({tag, "_ready_low_hold_full"}, tx_ready, 1'b0);
    exp_bits.delete();
    build_frame(data, nb, par, stop2);
    step();
    check({tag, "_txd_high_first_edge"}, txd, 1'b1);
    check({tag, "_busy_at_start"}, busy, 1'b1);
    check({tag, "_ready_after_consume"}, tx_ready, 1'b1);
    // Config changes during the frame must not affect it.
    cfg_divisor   = 16'($urandom_range(0, 7));
    cfg_data_bits = 4'($urandom_range(0, 15));
    cfg_parity    = parity_e'($urandom_range(0, 2));
    cfg_stop2     = 1'($urandom_range(0, 1));
    tx_data       = 8'($urandom);
    check_frame(tag, div);
    check({tag, "_ready_after"}, tx_ready, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    cfg_divisor   = 16'd0;
    cfg_data_bits = 4'd8;
    cfg_parity    = PARITY_NONE;
    cfg_stop2     = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
`ifdef UART_TX_CTS_EN
    cts_n         = 1'b0;
`endif
    step();
    step();
    check("reset_txd", txd, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", tx_ready, 1'b1);
    rst = 1'b0;
    step();
    step();

    // 8N1 divisor 3
    run_frame("t1_55", 8'h55, 8, 0, 1'b0, 3);

    // 7E2 divisor 1, parity 0 then 1
    run_frame("t2_41", 8'h41, 7, 1, 1'b1, 1);
    run_frame("t2_43", 8'h43, 7, 1, 1'b1, 1);

    // Back-to-back, divisor 0, 8N1
    wait_idle();
    cfg_divisor   = 16'd0;
    cfg_data_bits = 4'd8;
    cfg_parity    = PARITY_NONE;
    cfg_stop2     = 1'b0;
    exp_bits.delete();
    build_frame(8'hA5, 8, 0, 1'b0);
    build_frame(8'h3C, 8, 0, 1'b0);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    check("t3_ready_low_full", tx_ready, 1'b0);
    tx_data = 8'h3C;
    step();
    check("t3_ready_after_consume", tx_ready, 1'b1);
    check("t3_busy_start", busy, 1'b1);
    check("t3_txd_latency", txd, 1'b1);
    step();
    tx_valid = 1'b0;
    check("t3_ready_low_second", tx_ready, 1'b0);
    check("t3_bit0", txd, exp_bits[0]);
    check("t3_busy0", busy, 1'b1);
    for (int i = 1; i < 20; i++) begin
      step();
      check($sformatf("t3_bit%0d", i), txd, exp_bits[i]);
      if (i < 19) check($sformatf("t3_busy%0d", i), busy, 1'b1);
      else        check("t3_busy_end", busy, 1'b0);
    end
    step();
    check("t3_txd_idle", txd, 1'b1);
    check("t3_ready_idle", tx_ready, 1'b1);

    // 5O1 with all-ones data; lengths below 5 clamp up, above 8 clamp down
    run_frame("t4_5o1", 8'hFF, 5, 2, 1'b0, $urandom_range(0, 3));
    run_frame("t4_3o1", 8'hFF, 3, 2, 1'b0, $urandom_range(0, 3));
    run_frame("t4_15e2", 8'h96, 15, 1, 1'b1, $urandom_range(0, 3));

    // Reset during data bit 4
    wait_idle();
    cfg_divisor   = 16'd2;
    cfg_data_bits = 4'd8;
    cfg_parity    = PARITY_NONE;
    cfg_stop2     = 1'b0;
    tx_data       = 8'($urandom);
    tx_valid      = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    for (int i = 0; i < 17; i++) step();
    check("t5_busy_mid_frame", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_reset_txd", txd, 1'b1);
    check("t5_reset_busy", busy, 1'b0);
    check("t5_reset_ready", tx_ready, 1'b1);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    run_frame("t5_0f", 8'h0F, 8, 0, 1'b0, $urandom_range(0, 4));

    // Randomized frames
    for (int r = 0; r < 10; r++) begin
      run_frame($sformatf("rnd%0d", r), 8'($urandom), $urandom_range(0, 15),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

`ifdef UART_TX_CTS_EN
    begin
      int t;
      wait_idle();
      cts_n         = 1'b1;
      cfg_divisor   = 16'd1;
      cfg_data_bits = 4'd8;
      cfg_parity    = PARITY_NONE;
      cfg_stop2     = 1'b0;
      step();
      step();
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
        step();
        check("t6_held_txd", txd, 1'b1);
      end
      check("t6_held_busy", busy, 1'b0);
      exp_bits.delete();
      build_frame(8'h5A, 8, 0, 1'b0);
      cts_n = 1'b0;
      t = 0;
      while (busy !== 1'b1 && t < 10) begin
        step();
        t++;
      end
      check("t6_cts_start_latency_ok", (t <= 3), 1'b1);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      cts_n    = 1'b1;
      check_frame("t6_f1", 1);
      check("t6_pending_ready", tx_ready, 1'b0);
      tx_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        check("t6_pending_txd", txd, 1'b1);
      end
      check("t6_pending_busy", busy, 1'b0);
      exp_bits.delete();
      build_frame(8'hC3, 8, 0, 1'b0);
      cts_n = 1'b0;
      t = 0;
      while (busy !== 1'b1 && t < 10) begin
        step();
        t++;
      end
      check("t6_cts_start2_ok", (t <= 3), 1'b1);
      check_frame("t6_f2", 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
